// File: rtl/program_loader.sv
// Streams a byte image into the unified RAM, then releases the CPU from hold.
// Optional trailing checksum byte is enabled with `define LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic [DATA_WIDTH-1:0] byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_FINISH} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FINISH} state_t;
`endif

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] r_last;
  logic [ADDR_WIDTH-1:0] w_last;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic                  r_cpu_hold;
  logic                  r_done;
  logic                  w_xfer;
  logic                  w_at_last;

  // Zero or oversize lengths mean a full-RAM image; store len-1 so the
  // end-of-image compare fits the address width.
  assign w_last = (load_len == '0 || load_len > LP_DEPTH) ? ADDR_WIDTH'(DEPTH - 1)
                                                         : load_len[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_sum;
  logic                  r_err;
  assign byte_ready = (r_state == S_LOAD) || (r_state == S_CHECK);
  assign err        = r_err;
`else
  assign byte_ready = (r_state == S_LOAD);
  assign err        = 1'b0;
`endif

  assign busy           = byte_ready;
  assign w_xfer         = byte_valid && byte_ready && !abort;
  assign w_at_last      = (r_cnt == r_last);
  assign mem_write_en   = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_data;
  assign cpu_hold       = r_cpu_hold;
  assign done           = r_done;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // NOTE: w_next is defaulted before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_LOAD;
      S_LOAD: begin
        if (abort) w_next = S_IDLE;
`ifdef LOADER_CHECKSUM_EN
        else if (w_xfer && w_at_last) w_next = S_CHECK;
`else
        else if (w_xfer && w_at_last) w_next = S_FINISH;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (abort)       w_next = S_IDLE;
        else if (w_xfer) w_next = (byte_in == r_sum) ? S_FINISH : S_IDLE;
      end
`endif
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_last     <= '0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum      <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_last     <= w_last;
          r_cnt      <= '0;
          r_cpu_hold <= 1'b1;
          r_done     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
          r_sum      <= '0;
          r_err      <= 1'b0;
`endif
        end
        S_LOAD: begin
          if (abort) begin
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_err      <= 1'b0;
`endif
          end else if (w_xfer) begin
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_cnt;
            r_mem_data <= byte_in;
            if (!w_at_last) r_cnt <= r_cnt + ADDR_WIDTH'(1);
`ifdef LOADER_CHECKSUM_EN
            r_sum      <= r_sum + byte_in;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (abort) begin
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
          end else if (w_xfer && byte_in != r_sum) begin
            r_err      <= 1'b1;
          end
        end
`endif
        // Release lands the cycle after FINISH, never alongside the last write.
        S_FINISH: begin
          r_cpu_hold <= 1'b0;
          r_done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
